// File: rtl/sdram_host_responder.sv
// Host-side SDRAM controller emulator: request/ACK/burst handshake in front of a
// 256x16 synchronous RAM, with optional read-data corruption at one word address.
module sdram_host_responder #(
   parameter int unsigned ACK_LAT    = 3,
   parameter logic [22:0] FAULT_ADDR = 23'h000000,
   parameter logic [15:0] FAULT_XOR  = 16'h0000
) (
   input  logic        CLOCK_50,
   input  logic        RESET,
   input  logic [22:0] ADDR,
   input  logic        WR,
   input  logic        RD,
   input  logic [7:0]  LENGTH,
   input  logic [1:0]  DM,
   input  logic [15:0] DATAIN,
   output logic [15:0] DATAOUT,
   output logic        ACT,
   output logic        DONE,
   output logic        IN_REQ,
   output logic        OUT_VALID
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_WBURST,
      S_RBURST,
      S_RLAST,
      S_DONE_P,
      S_RELEASE
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(ACK_LAT - 1);

   state_t      state_q, state_d;
   logic [22:0] addr_q, addr_d;
   logic [7:0]  last_q, last_d;
   logic [1:0]  dm_q, dm_d;
   logic        wr_q, wr_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  off_q, off_d;
   logic [15:0] dout_q;
   logic        valid_q;

   logic [15:0] mem [256];
   logic [22:0] word_addr;
   logic [7:0]  idx;
   logic [15:0] rmask;

   // Full-width sum drives the fault compare; its low byte is the 8-bit wrapping RAM index.
   assign word_addr = addr_q + {15'd0, off_q};
   assign idx       = word_addr[7:0];
   assign rmask     = (word_addr == FAULT_ADDR) ? FAULT_XOR : 16'h0000;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      last_d  = last_q;
      dm_d    = dm_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      off_d   = off_q;
      ACT     = 1'b0;
      IN_REQ  = 1'b0;
      DONE    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (WR || RD) begin
               addr_d  = ADDR;
               last_d  = (LENGTH == 8'd0) ? 8'd0 : LENGTH - 8'd1;
               dm_d    = DM;
               wr_d    = WR;
               cnt_d   = '0;
               off_d   = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               ACT     = 1'b1;
               off_d   = '0;
               state_d = wr_q ? S_WBURST : S_RBURST;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_WBURST: begin
            IN_REQ = 1'b1;
            if (off_q == last_q) state_d = S_DONE_P;
            else                 off_d   = off_q + 8'd1;
         end
         S_RBURST: begin
            if (off_q == last_q) state_d = S_RLAST;
            else                 off_d   = off_q + 8'd1;
         end
         S_RLAST:  state_d = S_DONE_P;
         S_DONE_P: begin
            DONE    = 1'b1;
            state_d = S_RELEASE;
         end
         S_RELEASE: begin
            if (!WR && !RD) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         last_q  <= '0;
         dm_q    <= '0;
         wr_q    <= 1'b0;
         cnt_q   <= '0;
         off_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         last_q  <= last_d;
         dm_q    <= dm_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         off_q   <= off_d;
      end
   end

   // The RAM read register doubles as DATAOUT so it only moves on OUT_VALID.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         dout_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= (state_q == S_RBURST);
         if (state_q == S_RBURST) dout_q <= mem[idx] ^ rmask;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (state_q == S_WBURST) begin
         mem[idx] <= {dm_q[1] ? mem[idx][15:8] : DATAIN[15:8],
                      dm_q[0] ? mem[idx][7:0]  : DATAIN[7:0]};
      end
   end

   assign DATAOUT   = dout_q;
   assign OUT_VALID = valid_q;

endmodule

// File: tb/tb_sdram_host_responder.sv
// Randomized bench for sdram_host_responder against a cycle-timed transaction model
// built from the request/ACK/burst timing rules and a plain 256-word memory array.
module tb_sdram_host_responder;

   localparam int unsigned LAT = 3;
   localparam logic [22:0] FA  = 23'h000010;
   localparam logic [15:0] FX  = 16'h0001;

   logic        clk = 1'b0;
   logic        rst;
   logic [22:0] addr;
   logic        wr, rd;
   logic [7:0]  len;
   logic [1:0]  dm;
   logic [15:0] din, dout;
   logic        act, done, in_req, ovalid;

   int checks = 0;
   int errors = 0;
   logic [15:0] mem_m [256];
   logic [15:0] exp_dout;
   logic [15:0] wq[$];

   sdram_host_responder #(
      .ACK_LAT   (LAT),
      .FAULT_ADDR(FA),
      .FAULT_XOR (FX)
   ) dut (
      .CLOCK_50 (clk),
      .RESET    (rst),
      .ADDR     (addr),
      .WR       (wr),
      .RD       (rd),
      .LENGTH   (len),
      .DM       (dm),
      .DATAIN   (din),
      .DATAOUT  (dout),
      .ACT      (act),
      .DONE     (done),
      .IN_REQ   (in_req),
      .OUT_VALID(ovalid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] rd_model(input logic [22:0] a, input int i);
      logic [22:0] full;
      logic [7:0]  ix;
      full = a + 23'(i);
      ix   = a[7:0] + 8'(i);
      return mem_m[ix] ^ ((full == FA) ? FX : 16'h0000);
   endfunction

   // One request from IDLE through RELEASE; rst_at >= 0 aborts with RESET in that cycle.
   task automatic txn(input bit is_wr, input logic [22:0] a, input logic [7:0] l,
                      input logic [1:0] m, input int hold, input int rst_at);
      int          n;
      int          done_k;
      int          w, r;
      logic [15:0] wd [256];
      logic [3:0]  exp_s;
      logic [7:0]  ix;
      logic [1:0]  v;
      n      = (l == 8'd0) ? 1 : int'(l);
      done_k = int'(LAT) + n + (is_wr ? 1 : 2);
      for (int i = 0; i < n; i++) wd[i] = (wq.size() > 0) ? wq.pop_front() : 16'($urandom);
      for (int k = 0; k <= done_k; k++) begin
         @(posedge clk); #1;
         if (k == 0) begin
            wr = is_wr; rd = is_wr ? 1'($urandom) : 1'b1;
            addr = a; len = l; dm = m;
         end else begin
            addr = 23'($urandom); len = 8'($urandom); dm = 2'($urandom);
         end
         w = k - int'(LAT) - 1;
         r = k - int'(LAT) - 2;
         din = (is_wr && w >= 0 && w < n) ? wd[w] : 16'($urandom);
         if (k == rst_at) rst = 1'b1;
         @(negedge clk);
         if (rst_at >= 0 && k >= rst_at) begin
            exp_s = '0; exp_dout = '0;
         end else begin
            exp_s = {k == int'(LAT), is_wr && w >= 0 && w < n,
                     !is_wr && r >= 0 && r < n, k == done_k};
            if (is_wr && w >= 0 && w < n) begin
               ix = a[7:0] + 8'(w);
               mem_m[ix] = {m[1] ? mem_m[ix][15:8] : wd[w][15:8],
                            m[0] ? mem_m[ix][7:0]  : wd[w][7:0]};
            end
            if (!is_wr && r >= 0 && r < n) exp_dout = rd_model(a, r);
         end
         check("strobes", {28'd0, act, in_req, ovalid, done}, {28'd0, exp_s});
         check("dataout", {16'd0, dout}, {16'd0, exp_dout});
         if (k == rst_at) begin
            @(posedge clk); #1;
            rst = 1'b0; wr = 1'b0; rd = 1'b0;
            @(negedge clk);
            check("post_rst", {27'd0, act, in_req, ovalid, done, 1'b0}, 32'd0);
            check("post_rst_dout", {16'd0, dout}, 32'd0);
            return;
         end
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         v = 2'($urandom_range(1, 3));
         wr = v[1]; rd = v[0];
         addr = 23'($urandom); len = 8'($urandom);
         @(negedge clk);
         check("held_req", {28'd0, act, in_req, ovalid, done}, 32'd0);
         check("held_dout", {16'd0, dout}, {16'd0, exp_dout});
      end
      @(posedge clk); #1;
      wr = 1'b0; rd = 1'b0;
      @(negedge clk);
      check("release", {28'd0, act, in_req, ovalid, done}, 32'd0);
   endtask

   initial begin
      logic        is_wr;
      logic [22:0] a;
      logic [7:0]  l;
      int          ra;
      rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; len = '0; dm = '0; din = '0;
      exp_dout = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_strobes", {28'd0, act, in_req, ovalid, done}, 32'd0);
      check("rst_dout", {16'd0, dout}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Fill the whole RAM so every later read has a known model value.
      txn(1, 23'd0, 8'd255, 2'b00, 0, -1);
      txn(1, 23'd255, 8'd1, 2'b00, 0, -1);

      wq = {16'h5555};
      txn(1, 23'd5, 8'd1, 2'b00, 0, -1);
      txn(0, 23'd5, 8'd1, 2'b00, 0, -1);
      check("r5_hold", {16'd0, dout}, 32'h5555);

      txn(1, 23'd9, 8'd0, 2'b00, 0, -1);

      wq = {16'h0001, 16'h0002, 16'h0003, 16'h0004};
      txn(1, 23'h0000FE, 8'd4, 2'b00, 0, -1);
      txn(0, 23'h0000FE, 8'd4, 2'b00, 0, -1);
      check("wrap_last", {16'd0, dout}, 32'h0004);

      wq = {16'hFFFF};
      txn(1, 23'd2, 8'd1, 2'b00, 0, -1);
      wq = {16'h0000};
      txn(1, 23'd2, 8'd1, 2'b10, 0, -1);
      txn(0, 23'd2, 8'd1, 2'b00, 0, -1);
      check("dm_mask", {16'd0, dout}, 32'hFF00);

      wq = {16'h5555};
      txn(1, 23'h000010, 8'd1, 2'b00, 0, -1);
      txn(0, 23'h000010, 8'd1, 2'b00, 0, -1);
      check("fault_hit", {16'd0, dout}, 32'h5554);
      wq = {16'h5555};
      txn(1, 23'h000110, 8'd1, 2'b00, 0, -1);
      txn(0, 23'h000110, 8'd1, 2'b00, 0, -1);
      check("fault_alias", {16'd0, dout}, 32'h5555);
      txn(0, 23'h00000C, 8'd8, 2'b00, 0, -1);

      txn(1, 23'h000030, 8'd2, 2'b00, 5, -1);

      wq = {16'hA001, 16'hA002, 16'hA003, 16'hA004};
      txn(1, 23'h000040, 8'd4, 2'b00, 0, int'(LAT) + 3);
      txn(0, 23'h000040, 8'd4, 2'b00, 0, -1);

      repeat (40) begin
         is_wr = 1'($urandom);
         a     = {(($urandom % 2) == 0) ? 15'd0 : 15'($urandom), 8'($urandom)};
         l     = (($urandom % 8) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
         ra    = (($urandom % 10) == 0) ? int'($urandom_range(1, LAT + 2)) : -1;
         txn(is_wr, a, l, 2'($urandom), int'($urandom_range(0, 3)), ra);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
